// File: rtl/decypher_pkg.sv
// Shared definitions for the decypher OTP decryption engine: default sizes,
// FSM state encoding and the block-counter width helper.
package decypher_pkg;

   localparam int unsigned MsgSizeDefault = 32;
   localparam int unsigned KeySizeDefault = 8;

   typedef enum logic [1:0] {
      DcIdle = 2'd0,
      DcRun  = 2'd1,
      DcDone = 2'd2
   } dc_state_e;

   // Counter needs at least one bit even for a single-block message.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/decypher_block_xor.sv
// Combinational pad application: one ciphertext block XOR one key block.
module decypher_block_xor #(
   parameter int unsigned KEY_SIZE = 8
) (
   input  logic [KEY_SIZE-1:0] blk_i,
   input  logic [KEY_SIZE-1:0] key_i,
   output logic [KEY_SIZE-1:0] res_o
);

   assign res_o = blk_i ^ key_i;

endmodule

// File: rtl/decypher.sv
// One-time-pad decryptor: consumes the ciphertext MSB block first, one key
// block per RUN cycle, and assembles the plaintext into the out register.
module decypher
   import decypher_pkg::*;
#(
   parameter int unsigned MSG_SIZE   = MsgSizeDefault,
   parameter int unsigned KEY_SIZE   = KeySizeDefault,
   parameter int unsigned NUM_BLOCKS = MSG_SIZE / KEY_SIZE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [MSG_SIZE-1:0] cipher,
   input  logic [KEY_SIZE-1:0] key,
   output logic                key_ready,
   output logic                busy,
   output logic                done,
   output logic [MSG_SIZE-1:0] out
);

   localparam int unsigned CntW = cnt_width(NUM_BLOCKS);
   localparam logic [CntW-1:0] LastBlk = CntW'(NUM_BLOCKS - 1);

   dc_state_e           state_q;
   logic [MSG_SIZE-1:0] shreg_q;
   logic [MSG_SIZE-1:0] out_q;
   logic [CntW-1:0]     cnt_q;
   logic                busy_q;
   logic                done_q;
   logic [KEY_SIZE-1:0] blk;

   decypher_block_xor #(
      .KEY_SIZE(KEY_SIZE)
   ) u_block_xor (
      .blk_i(shreg_q[MSG_SIZE-1 -: KEY_SIZE]),
      .key_i(key),
      .res_o(blk)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DcIdle;
         shreg_q <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            DcIdle, DcDone: begin
               // DONE with start behaves as IDLE with start: back-to-back messages.
               if (start) begin
                  shreg_q <= cipher;
                  out_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= DcRun;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= DcIdle;
               end
            end
            DcRun: begin
               out_q   <= (out_q << KEY_SIZE) | MSG_SIZE'(blk);
               shreg_q <= shreg_q << KEY_SIZE;
               cnt_q   <= cnt_q + CntW'(1);
               if (cnt_q == LastBlk) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DcDone;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= DcIdle;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign key_ready = busy_q;
   assign done      = done_q;
   assign out       = out_q;

endmodule

// File: tb/tb_decypher.sv
// Self-checking bench for decypher (32-bit message, 8-bit key) against a
// byte-level OTP reference model.
module tb_decypher;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] cipher;
   logic [7:0]  key;
   logic        key_ready;
   logic        busy;
   logic        done;
   logic [31:0] out_w;

   int n_checks;
   int n_fail;

   decypher #(
      .MSG_SIZE(32),
      .KEY_SIZE(8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .cipher   (cipher),
      .key      (key),
      .key_ready(key_ready),
      .busy     (busy),
      .done     (done),
      .out      (out_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Pad byte i applies to message byte i counted from the MSB end.
   function automatic logic [31:0] otp(input logic [31:0] msg, input logic [7:0] pad[4]);
      byte unsigned b[4];
      logic [31:0]  r;
      for (int i = 0; i < 4; i++) b[i] = msg[31-8*i -: 8];
      r = 0;
      for (int i = 0; i < 4; i++) r = (r << 8) | 32'(b[i] ^ pad[i]);
      return r;
   endfunction

   // Full message; glitch_at>0 raises start with 0xFFFFFFFF before edge E<glitch_at>.
   task automatic run_msg(input string tag, input logic [31:0] c, input logic [7:0] pad[4],
                          input int glitch_at, input logic [31:0] exp);
      @(negedge clk);
      start  = 1'b1;
      cipher = c;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_kr"}, 32'(key_ready), 32'd1);
         check({tag, "_done_run"}, 32'(done), 32'd0);
         start = (glitch_at == i + 1);
         if (glitch_at == i + 1) cipher = 32'hFFFF_FFFF;
         key = pad[i];
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_out"}, out_w, exp);
      @(negedge clk);
      check({tag, "_done_end"}, 32'(done), 32'd0);
      check({tag, "_kr_idle"}, 32'(key_ready), 32'd0);
      check({tag, "_out_hold"}, out_w, exp);
   endtask

   logic [7:0]  pad[4];
   logic [7:0]  pad_ff[4];
   logic [31:0] p;
   logic [31:0] c;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      cipher   = '0;
      key      = '0;
      pad_ff   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      #12;
      check("rst_out", out_w, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_kr", 32'(key_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      key = 8'hFF;
      run_msg("const_key", 32'h1234_5678, pad_ff, 0, 32'hEDCB_A987);

      pad = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
      run_msg("stream", 32'h0, pad, 0, 32'hA53C_0FF0);

      run_msg("start_in_run", 32'h1234_5678, pad_ff, 2, 32'hEDCB_A987);
      repeat (3) begin
         @(negedge clk);
         check("start_in_run_no_extra_done", 32'(done), 32'd0);
      end

      for (int it = 0; it < 100; it++) begin
         p = $urandom;
         for (int i = 0; i < 4; i++) pad[i] = 8'($urandom_range(0, 255));
         c = otp(p, pad);
         run_msg("round_trip", c, pad, 0, p);
      end

      // Back-to-back: start held through the DONE cycle.
      @(negedge clk);
      start  = 1'b1;
      cipher = 32'h1234_5678;
      key    = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      check("b2b_done1", 32'(done), 32'd1);
      check("b2b_out1", out_w, 32'hEDCB_A987);
      start  = 1'b1;
      cipher = 32'h0101_0101;
      key    = 8'h01;
      @(negedge clk);
      start = 1'b0;
      check("b2b_done_gap", 32'(done), 32'd0);
      check("b2b_busy2", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("b2b_done_early", 32'(done), 32'd0);
      @(negedge clk);
      check("b2b_done2", 32'(done), 32'd1);
      check("b2b_out2", out_w, 32'h0);

      // Reset mid-run between E2 and E3.
      @(negedge clk);
      start  = 1'b1;
      cipher = 32'h1234_5678;
      key    = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", out_w, 32'h0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_kr", 32'(key_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("mid_rst_no_done", 32'(done), 32'd0);
      end
      run_msg("after_rst", 32'h1234_5678, pad_ff, 0, 32'hEDCB_A987);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decypher.md
Name: decypher

Overview:
- One-time-pad decryption engine; inverse of the `cypher` encryption path.
- Accepts a full ciphertext word, splits it into KEY_SIZE blocks MSB-first, and XORs each block with the key presented that cycle.
- Reassembles the plaintext in an output register and signals completion with a one-cycle `done` pulse.
- Sits at the receive end of the OTP link; its block order and key order match the encryptor, so a `cypher` → `decypher` chain fed the same key stream is an identity.

Parameters:
- MSG_SIZE, default `MSG_SIZE (from constants.vh), ciphertext/plaintext width in bits.
- KEY_SIZE, default `KEY_SIZE (from constants.vh), block and key width in bits. MSG_SIZE must be an integer multiple of KEY_SIZE.
- NUM_BLOCKS, default MSG_SIZE/KEY_SIZE, blocks per message (derived; must be ≥ 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to decrypt `cipher`; sampled on a clk rising edge.
- cipher  input  MSG_SIZE  ciphertext; captured only on the edge where start is accepted.
- key  input  KEY_SIZE  pad block for the current cycle; sampled on each RUN edge.
- key_ready  output  1  high while in RUN; the current `key` is consumed at the next edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; `out` is complete.
- out  output  MSG_SIZE  plaintext; valid from `done` until the next accepted start.

Behaviour:
- Reset:
  - Asynchronous, active-low; reset is asynchronous and active-low, single clock clk.
  - Takes effect immediately, including mid-operation.
  - state=IDLE; out, shift register and block counter = 0; busy=key_ready=done=0.
  - Any in-flight message is discarded; no done pulse is produced.
- States:
  - IDLE: wait for start.
  - RUN: one block per edge, NUM_BLOCKS edges.
  - DONE: single cycle, done=1.
- Transitions:
  - IDLE with start=1: cipher loads into the shift register, counter=0, out is cleared to 0, state goes to RUN.
  - IDLE with start=0: stay in IDLE.
  - RUN, each edge:
    - blk = top KEY_SIZE bits of shift register XOR key.
    - out <= {out[MSG_SIZE-KEY_SIZE-1:0], blk}.
    - Shift register shifts left by KEY_SIZE, zero-fill.
    - Counter increments.
  - RUN, on the edge processing block NUM_BLOCKS-1: state goes to DONE.
  - DONE with start=1: treated exactly as IDLE with start=1 (back-to-back message; new cipher captured; done deasserts next cycle).
  - DONE with start=0: state goes to IDLE.
- Latency:
  - Start accepted at edge E0.
  - Blocks processed at E1..E_NUM_BLOCKS.
  - done is high during the cycle after E_NUM_BLOCKS, i.e. NUM_BLOCKS+1 edges after E0 its pulse ends.
- Ordering: block 0 = cipher[MSG_SIZE-1 -: KEY_SIZE] uses the key sampled at E1 and lands in out MSBs.
- start while in RUN: ignored; the cipher input is not sampled.
- key may change every RUN cycle (streamed pad); its value outside RUN is don't-care.
- Outputs:
  - All outputs are registered or decoded from the state register only.
  - No combinational path from start to busy.
- out holds its value in IDLE after DONE; it changes only in RUN or on start acceptance.
- Counter width: clog2(NUM_BLOCKS), minimum 1 bit. Counter wraps to 0 on entry to RUN.

Decomposition:
- constants.vh:
  - Existing MSG_SIZE and KEY_SIZE.
  - Add DC_IDLE=2'd0, DC_RUN=2'd1, DC_DONE=2'd2 state encodings.
- One natural sub-module, block_xor: purely combinational KEY_SIZE-wide XOR of block and key, instanced once.
- FSM, counter, shift register and out register stay in decypher.

Test Plan:
All cases use MSG_SIZE=32, KEY_SIZE=8.
1. Constant key: cipher=0x12345678, key held 0xFF, start pulse at E0 → out=0xEDCBA987; done high exactly one cycle after E4; busy high for 4 cycles.
2. Streamed pad: cipher=0x00000000, key=0xA5,0x3C,0x0F,0xF0 on E1..E4 → out=0xA53C0FF0; key_ready high on exactly those 4 cycles.
3. Round trip: random 32-bit plaintext P and random 4-byte pad through `cypher`, then through decypher with the same pad order → out==P (100 iterations).
4. Start during RUN: second start at E2 with cipher=0xFFFFFFFF → ignored; result from scenario 1 unchanged; exactly one done pulse.
5. Back-to-back: start held high through the DONE cycle with a new cipher=0x01010101 and key=0x01 → first out valid at done, second out=0x00000000 after 4 further edges, done pulses twice.
6. Reset mid-run: rst_n low between E2 and E3 → out=0, busy=0, done never pulses; a subsequent start of scenario 1 yields 0xEDCBA987.
